// File: rtl/heat_column_if.sv
// Request/acknowledge link between one heat_column and the VGA write arbiter.
interface heat_column_if;
  logic        inter_start;
  logic        comp_flag;
  logic [31:0] vga_addr;
  logic [31:0] vga_pxl_clr;
  logic        inter_select;
  logic        inter_done;

  modport master (
    input  inter_start, comp_flag,
    output vga_addr, vga_pxl_clr, inter_select, inter_done
  );

  modport slave (
    output inter_start, comp_flag,
    input  vga_addr, vga_pxl_clr, inter_select, inter_done
  );
endinterface

// File: rtl/heat_column.sv
// One screen column of a 1-D heat-diffusion simulation: initialise, run Jacobi
// sweeps with fixed hot/cold ends, then hand each row's pixel to the arbiter.
module heat_column #(
  parameter int          COLUMN   = 0,
  parameter int          ROWS     = 480,
  parameter int          STEPS    = 64,
  parameter int          SCREEN_W = 640,
  parameter int          K_SHIFT  = 2,
  parameter logic [15:0] T_HOT    = 16'hFF00,
  parameter logic [15:0] T_COLD   = 16'h0000,
  parameter logic [15:0] T_INIT   = 16'h8000
) (
  input  logic          clk,
  input  logic          reset,
  heat_column_if.master bus
);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int CYC_W  = $clog2(ROWS + 2);
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [CYC_W-1:0]  CYC_ROWS  = CYC_W'(ROWS);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(ROWS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SWEEP, S_PLOT_REQ, S_PLOT_ACK, S_PLOT_GAP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          clr_q, clr_d;
  logic                sel_q, sel_d;
  logic                done_q, done_d;

  logic [15:0]         mem_q [ROWS];
  logic [15:0]         rdata_q, up_q, old_q;
  logic                we;
  logic [ROW_W-1:0]    waddr, raddr;
  logic [15:0]         wdata, new_val;
  logic signed [17:0]  lap, lap_sh;
  logic signed [18:0]  upd;

  function automatic logic [15:0] sat_u16(input logic signed [18:0] v);
    if (v < 0)                 return 16'h0000;
    else if (v > 19'sd65535)   return 16'hFFFF;
    else                       return v[15:0];
  endfunction

  // RGB332: top intensity bits drive red, their inverse drives blue.
  function automatic logic [7:0] colour(input logic [15:0] t);
    return {t[15:13], 3'b000, ~t[15:14]};
  endfunction

  // Stage boundary: window up/old/rdata -> saturated update of row old.
  always_comb begin
    lap     = {2'b00, up_q} + {2'b00, rdata_q} - {1'b0, old_q, 1'b0};
    lap_sh  = lap >>> K_SHIFT;
    upd     = {3'b000, old_q} + {lap_sh[17], lap_sh};
    new_val = sat_u16(upd);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cyc_d   = cyc_q;
    step_d  = step_q;
    addr_d  = addr_q;
    clr_d   = clr_q;
    sel_d   = sel_q;
    done_d  = done_q;
    we      = 1'b0;
    waddr   = row_q;
    wdata   = new_val;
    raddr   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.inter_start) begin
          state_d = S_INIT;
          row_d   = '0;
        end
      end
      S_INIT: begin
        we    = 1'b1;
        wdata = (row_q == '0) ? T_HOT : (row_q == LAST_ROW) ? T_COLD : T_INIT;
        if (row_q == LAST_ROW) begin
          state_d = S_SWEEP;
          cyc_d   = '0;
          step_d  = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_SWEEP: begin
        // Cycle c reads row c; row c-2 is written two cycles later once its lower neighbour arrives.
        if (cyc_q < CYC_ROWS) raddr = cyc_q[ROW_W-1:0];
        if (cyc_q >= CYC_W'(3) && cyc_q <= CYC_ROWS) begin
          we    = 1'b1;
          waddr = ROW_W'(cyc_q - CYC_W'(2));
        end
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (step_q == STEP_LAST) begin
            state_d = S_PLOT_REQ;
            row_d   = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_PLOT_REQ: begin
        addr_d  = 32'(COLUMN) + 32'(row_q) * 32'(SCREEN_W);
        clr_d   = colour(rdata_q);
        sel_d   = 1'b1;
        state_d = S_PLOT_ACK;
      end
      S_PLOT_ACK: begin
        if (bus.comp_flag) begin
          sel_d   = 1'b0;
          state_d = S_PLOT_GAP;
        end
      end
      S_PLOT_GAP: begin
        if (row_q != LAST_ROW) raddr = row_q + 1'b1;
        if (!bus.comp_flag) begin
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_PLOT_REQ;
          end
        end
      end
      S_DONE: begin
        if (bus.inter_start) begin
          done_d  = 1'b0;
          row_d   = '0;
          state_d = S_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cyc_q   <= '0;
      step_q  <= '0;
      addr_q  <= '0;
      clr_q   <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cyc_q   <= cyc_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      clr_q   <= clr_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (state_q == S_SWEEP && cyc_q != '0 && cyc_q <= CYC_ROWS) begin
      up_q  <= old_q;
      old_q <= rdata_q;
    end
  end

  assign bus.vga_addr     = addr_q;
  assign bus.vga_pxl_clr  = {24'h0, clr_q};
  assign bus.inter_select = sel_q;
  assign bus.inter_done   = done_q;
endmodule
